// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with flush, bubble and stall; PIPE_STAGE_STALL_CNT_EN adds a stall-cycle counter
module pipe_stage_reg #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int EXC_W = 5,
  parameter logic [PC_W-1:0] EXC_ENTRY = PC_W'(32'h0000_4180),
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_0000)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               bubble,
  input  logic               clear_db,
  input  logic               int_req,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_isdb,
  input  logic [PC_W-1:0]    npc,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pcp8,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_isdb,
  output logic               out_valid,
  output logic [15:0]        stall_cnt
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [EXC_W-1:0] exc_q, exc_d;
  logic isdb_q, isdb_d, valid_q, valid_d, flush;
  always_comb begin
    flush = int_req | clear_db;
    pc_d = int_req ? EXC_ENTRY : clear_db ? npc : en ? in_pc : pc_q;
    // a faulting fetch must never reach decode as a real instruction
    instr_d = flush ? '0 : en ? ((bubble || in_exc != '0) ? '0 : in_instr) : instr_q;
    exc_d = flush ? '0 : en ? (bubble ? '0 : in_exc) : exc_q;
    isdb_d = flush ? 1'b0 : en ? in_isdb : isdb_q;
    valid_d = flush ? 1'b0 : en ? ~bubble : valid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      instr_q <= '0;
      exc_q <= '0;
      isdb_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      exc_q <= exc_d;
      isdb_q <= isdb_d;
      valid_q <= valid_d;
    end
  end
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (flush | en) ? 16'h0000 : (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'h0001;
  always_ff @(posedge clk) begin
    if (reset) stall_q <= 16'h0000;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif
  assign out_pc = pc_q;
  assign out_pcp8 = pc_q + PC_W'(8);
  assign out_instr = instr_q;
  assign out_exc = exc_q;
  assign out_isdb = isdb_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg, expected state pushed on drive and popped after the edge
module tb_pipe_stage_reg;
  logic clk = 1'b0, reset, en, bubble, clear_db, int_req, in_isdb;
  logic [31:0] in_pc, in_instr, npc, out_pc, out_pcp8, out_instr;
  logic [4:0] in_exc, out_exc;
  logic out_isdb, out_valid;
  logic [15:0] stall_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    string tag;
    logic [31:0] pc, pcp8, instr;
    logic [4:0] exc;
    logic isdb, valid;
    logic [15:0] stall;
  } exp_t;
  exp_t sb[$];
  logic [31:0] m_pc, m_instr;
  logic [4:0] m_exc;
  logic m_isdb, m_valid;
  int m_stall = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .en(en), .bubble(bubble), .clear_db(clear_db), .int_req(int_req),
    .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc), .in_isdb(in_isdb), .npc(npc),
    .out_pc(out_pc), .out_pcp8(out_pcp8), .out_instr(out_instr), .out_exc(out_exc),
    .out_isdb(out_isdb), .out_valid(out_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic b, input logic cdb,
                      input logic irq, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [4:0] ex, input logic db, input logic [31:0] np);
    exp_t x;
    reset = r; en = e; bubble = b; clear_db = cdb; int_req = irq;
    in_pc = pc; in_instr = ins; in_exc = ex; in_isdb = db; npc = np;
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_exc = 0; m_isdb = 0; m_valid = 0; m_stall = 0;
    end else if (irq) begin
      m_pc = 32'h0000_4180; m_instr = 0; m_exc = 0; m_isdb = 0; m_valid = 0; m_stall = 0;
    end else if (cdb) begin
      m_pc = np; m_instr = 0; m_exc = 0; m_isdb = 0; m_valid = 0; m_stall = 0;
    end else if (e && b) begin
      m_pc = pc; m_instr = 0; m_exc = 0; m_isdb = db; m_valid = 0; m_stall = 0;
    end else if (e) begin
      m_pc = pc; m_instr = (ex == 0) ? ins : 0; m_exc = ex; m_isdb = db; m_valid = 1; m_stall = 0;
    end else if (m_stall < 65535) m_stall++;
    x.tag = tag; x.pc = m_pc; x.pcp8 = m_pc + 32'd8; x.instr = m_instr; x.exc = m_exc;
    x.isdb = m_isdb; x.valid = m_valid;
`ifdef PIPE_STAGE_STALL_CNT_EN
    x.stall = 16'(m_stall);
`else
    x.stall = 16'h0000;
`endif
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".pc"}, out_pc, x.pc);
    chk({x.tag, ".pcp8"}, out_pcp8, x.pcp8);
    chk({x.tag, ".instr"}, out_instr, x.instr);
    chk({x.tag, ".exc"}, 32'(out_exc), 32'(x.exc));
    chk({x.tag, ".isdb"}, 32'(out_isdb), 32'(x.isdb));
    chk({x.tag, ".valid"}, 32'(out_valid), 32'(x.valid));
    chk({x.tag, ".stall"}, 32'(stall_cnt), 32'(x.stall));
  endtask

  initial begin
    step("reset", 1, 1, 0, 0, 0, 32'h1234, 32'h5678, 5'd3, 1, 32'h9999);
    step("adv", 0, 1, 0, 0, 0, 32'h3000, 32'h2408_0001, 0, 0, 0);
    step("fault", 0, 1, 0, 0, 0, 32'h3004, 32'hDEAD_BEEF, 5'd4, 0, 0);
    step("load", 0, 1, 0, 0, 0, 32'h3008, 32'h1111_2222, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 0, 0, 0, 0, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom);
    step("bub_noen", 0, 0, 1, 0, 0, 32'h7000, 32'h7777, 0, 0, 0);
    step("irq_cdb", 0, 0, 0, 1, 1, 32'h3010, 32'h1, 0, 0, 32'h3100);
    step("cdb", 0, 0, 0, 1, 0, 32'h3010, 32'h1, 0, 1, 32'h3100);
    step("bubble", 0, 1, 1, 0, 0, 32'h3104, 32'hABCD, 5'd2, 1, 0);
    step("wrap", 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0042, 0, 0, 0);
    step("stall2", 0, 0, 0, 0, 0, 32'h5, 32'h6, 0, 0, 0);
    step("stall3", 0, 0, 0, 0, 0, 32'h5, 32'h6, 0, 0, 0);
    step("rst_mid", 1, 0, 0, 0, 0, 32'h5, 32'h6, 0, 0, 0);
    step("post_rst", 0, 1, 0, 0, 0, 32'h3200, 32'h2409_0002, 0, 1, 0);
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, $urandom, $urandom,
           $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'd0, 1'($urandom), $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
